regfile_wb_arbiter: RTL and testbench

REGFILE_WB_ARBITER -- requirements
Module: regfile_wb_arbiter

---
 rtl/mips_pkg.sv | 15 +
 rtl/regfile_wb_fifo.sv | 51 +++++
 rtl/regfile_wb_arbiter.sv | 146 ++++++++++++++
 tb/tb_regfile_wb_arbiter.sv | 240 ++++++++++++++++++++++++
 4 files changed

// File: rtl/mips_pkg.sv
// Shared types and constants for the register-file writeback arbiter.
package mips_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    WAIT  = 2'd1,
    STALL = 2'd2
  } wb_state_e;

  localparam logic [4:0] REG_RA     = 5'd31;
  localparam int         WB_ADDR_W  = 5;
  localparam int         WB_DATA_W  = 32;
  localparam int         WB_ENTRY_W = WB_ADDR_W + WB_DATA_W;

endpackage

// File: rtl/regfile_wb_fifo.sv
// Two-entry FIFO holding {addr, data} multiply/divide results; head is visible combinationally.
// No added latency; push is ignored when full and pop is ignored when empty.
module regfile_wb_fifo
  import mips_pkg::*;
#(
  parameter int W = WB_ENTRY_W
) (
  input  logic         i_clk,
  input  logic         i_rst_n,
  input  logic         i_push,
  input  logic [W-1:0] i_push_dat,
  input  logic         i_pop,
  output logic [W-1:0] o_head_dat,
  output logic         o_empty,
  output logic         o_full,
  output logic [1:0]   o_count
);

  logic [W-1:0] r_mem [2];
  logic         r_wr_ptr;
  logic         r_rd_ptr;
  logic [1:0]   r_count;
  logic         w_push;
  logic         w_pop;

  assign w_push = i_push & (r_count != 2'd2);
  assign w_pop  = i_pop & (r_count != 2'd0);

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_mem[0] <= '0;
      r_mem[1] <= '0;
      r_wr_ptr <= 1'b0;
      r_rd_ptr <= 1'b0;
      r_count  <= 2'd0;
    end else begin
      if (w_push) begin
        r_mem[r_wr_ptr] <= i_push_dat;
        r_wr_ptr        <= ~r_wr_ptr;
      end
      if (w_pop) r_rd_ptr <= ~r_rd_ptr;
      r_count <= r_count + {1'b0, w_push} - {1'b0, w_pop};
    end
  end

  assign o_head_dat = r_mem[r_rd_ptr];
  assign o_empty    = (r_count == 2'd0);
  assign o_full     = (r_count == 2'd2);
  assign o_count    = r_count;

endmodule

// File: rtl/regfile_wb_arbiter.sv
// Shares the register-file write port between the pipeline (A, fixed priority) and a buffered mul/div port (B).
// Writes land one cycle after grant; b_ready drops when the FIFO is full, stall_req asks A to yield when B starves.
module regfile_wb_arbiter
  import mips_pkg::*;
#(
  parameter int STARVE_LIMIT = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        a_valid,
  input  logic [4:0]  a_addr,
  input  logic [31:0] a_data,
  input  logic        a_jal,
  input  logic        b_valid,
  output logic        b_ready,
  input  logic [4:0]  b_addr,
  input  logic [31:0] b_data,
  input  logic        iss_valid,
  input  logic [4:0]  iss_addr,
  input  logic [4:0]  chk_addr0,
  input  logic [4:0]  chk_addr1,
  output logic        hazard,
  output logic        stall_req,
  output logic        wr_en,
  output logic [4:0]  wr_addr,
  output logic [31:0] wr_data,
  output logic        JumpAndLink
);

  localparam logic [3:0] LIM = 4'(STARVE_LIMIT);

  logic                  w_full;
  logic                  w_empty;
  logic [1:0]            w_count;
  logic [1:0]            w_count_nxt;
  logic [WB_ENTRY_W-1:0] w_head;
  logic [4:0]            w_head_addr;
  logic [31:0]           w_head_data;
  logic                  w_b_push;
  logic                  w_grant_b;
  logic                  w_blocked;
  logic [31:0]           r_pend;
  logic [31:0]           w_pend_nxt;
  logic [3:0]            r_blk;
  logic [3:0]            w_blk_nxt;
  wb_state_e             r_state;
  wb_state_e             w_state_nxt;
  logic                  r_wr_en;
  logic [4:0]            r_wr_addr;
  logic [31:0]           r_wr_data;
  logic                  r_jal;

  assign b_ready     = ~w_full;
  assign w_b_push    = b_valid & ~w_full;
  assign w_grant_b   = ~a_valid & ~w_empty;
  assign w_blocked   = a_valid & ~w_empty;
  assign {w_head_addr, w_head_data} = w_head;
  assign w_count_nxt = w_count + {1'b0, w_b_push} - {1'b0, w_grant_b};

  regfile_wb_fifo #(.W(WB_ENTRY_W)) u_fifo (
    .i_clk      (clk),
    .i_rst_n    (rst),
    .i_push     (w_b_push),
    .i_push_dat ({b_addr, b_data}),
    .i_pop      (w_grant_b),
    .o_head_dat (w_head),
    .o_empty    (w_empty),
    .o_full     (w_full),
    .o_count    (w_count)
  );

  // Register 0 is never written; a B head aimed at it is still popped.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_wr_en   <= 1'b0;
      r_wr_addr <= 5'd0;
      r_wr_data <= 32'd0;
      r_jal     <= 1'b0;
    end else if (a_valid) begin
      r_wr_en   <= a_jal | (a_addr != 5'd0);
      r_wr_addr <= a_jal ? REG_RA : a_addr;
      r_wr_data <= a_data;
      r_jal     <= a_jal;
    end else if (w_grant_b) begin
      r_wr_en   <= (w_head_addr != 5'd0);
      r_wr_addr <= w_head_addr;
      r_wr_data <= w_head_data;
      r_jal     <= 1'b0;
    end else begin
      r_wr_en   <= 1'b0;
      r_jal     <= 1'b0;
    end
  end

  assign wr_en       = r_wr_en;
  assign wr_addr     = r_wr_addr;
  assign wr_data     = r_wr_data;
  assign JumpAndLink = r_jal;

  // A same-cycle issue wins over the retiring write to the same register.
  always_comb begin
    w_pend_nxt = r_pend;
    if (w_grant_b) w_pend_nxt[w_head_addr] = 1'b0;
    if (iss_valid) w_pend_nxt[iss_addr] = 1'b1;
    w_pend_nxt[0] = 1'b0;
  end

  always_comb begin
    w_blk_nxt = r_blk;
    if (w_grant_b || r_state == IDLE) w_blk_nxt = 4'd0;
    else if (w_blocked && r_blk < LIM) w_blk_nxt = r_blk + 4'd1;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_pend  <= 32'd0;
      r_blk   <= 4'd0;
      r_state <= IDLE;
    end else begin
      r_pend  <= w_pend_nxt;
      r_blk   <= w_blk_nxt;
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      IDLE:    if (w_b_push) w_state_nxt = WAIT;
      WAIT: begin
        if (w_count_nxt == 2'd0)    w_state_nxt = IDLE;
        else if (w_blk_nxt >= LIM)  w_state_nxt = STALL;
      end
      STALL:   if (w_grant_b) w_state_nxt = (w_count_nxt == 2'd0) ? IDLE : WAIT;
      default: w_state_nxt = IDLE;
    endcase
  end

  always_comb begin
    stall_req = 1'b0;
    if (r_state == STALL) stall_req = 1'b1;
  end

  assign hazard = r_pend[chk_addr0] | r_pend[chk_addr1];

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Scenario tasks plus a randomized run against a queue/bitmap model of the writeback arbiter.
module tb_regfile_wb_arbiter;

  localparam int LIM = 4;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        a_valid, a_jal, b_valid, iss_valid;
  logic [4:0]  a_addr, b_addr, iss_addr, chk_addr0, chk_addr1;
  logic [31:0] a_data, b_data;
  logic        b_ready, hazard, stall_req, wr_en, JumpAndLink;
  logic [4:0]  wr_addr;
  logic [31:0] wr_data;

  regfile_wb_arbiter #(.STARVE_LIMIT(LIM)) dut (
    .clk(clk), .rst(rst),
    .a_valid(a_valid), .a_addr(a_addr), .a_data(a_data), .a_jal(a_jal),
    .b_valid(b_valid), .b_ready(b_ready), .b_addr(b_addr), .b_data(b_data),
    .iss_valid(iss_valid), .iss_addr(iss_addr),
    .chk_addr0(chk_addr0), .chk_addr1(chk_addr1),
    .hazard(hazard), .stall_req(stall_req),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data), .JumpAndLink(JumpAndLink)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  // Reference model: FIFO as a queue, pending as a bitmap, starvation as a blocked-cycle count.
  logic [36:0] mq[$];
  bit   [31:0] mpend;
  int          mblk;
  bit          mstall;
  logic        e_en, e_jal;
  logic [4:0]  e_addr;
  logic [31:0] e_data;

  task automatic model_reset();
    mq.delete();
    mpend = '0; mblk = 0; mstall = 1'b0;
    e_en = 1'b0; e_jal = 1'b0; e_addr = '0; e_data = '0;
  endtask

  task automatic idle_inputs();
    a_valid = 0; a_jal = 0; a_addr = 0; a_data = 0;
    b_valid = 0; b_addr = 0; b_data = 0;
    iss_valid = 0; iss_addr = 0; chk_addr0 = 0; chk_addr1 = 0;
  endtask

  task automatic tick();
    int sz; logic [36:0] h; bit bg;
    sz = mq.size(); bg = 1'b0; h = '0;
    if (a_valid) begin
      e_en = a_jal | (a_addr != 5'd0); e_addr = a_jal ? 5'd31 : a_addr; e_data = a_data; e_jal = a_jal;
    end else if (sz > 0) begin
      h = mq.pop_front(); bg = 1'b1;
      e_en = (h[36:32] != 5'd0); e_addr = h[36:32]; e_data = h[31:0]; e_jal = 1'b0;
    end else begin
      e_en = 1'b0; e_jal = 1'b0;
    end
    if (b_valid && sz < 2) mq.push_back({b_addr, b_data});
    if (bg) mpend[h[36:32]] = 1'b0;
    if (iss_valid && iss_addr != 5'd0) mpend[iss_addr] = 1'b1;
    if (sz == 0 || bg) mblk = 0;
    else if (a_valid && mblk < LIM) mblk++;
    mstall = bg ? 1'b0 : (mstall || mblk >= LIM);
    @(posedge clk); #1;
  endtask

  task automatic test_reset();
    idle_inputs(); model_reset();
    rst = 1'b0;
    #12;
    n_checks++; if (wr_en !== 1'b0) begin n_errors++; $display("FAIL reset_wr_en: got %b want 0", wr_en); end
    n_checks++; if (wr_addr !== 5'd0) begin n_errors++; $display("FAIL reset_wr_addr: got %0d want 0", wr_addr); end
    n_checks++; if (wr_data !== 32'd0) begin n_errors++; $display("FAIL reset_wr_data: got %h want 0", wr_data); end
    n_checks++; if (JumpAndLink !== 1'b0) begin n_errors++; $display("FAIL reset_jal: got %b want 0", JumpAndLink); end
    n_checks++; if (stall_req !== 1'b0) begin n_errors++; $display("FAIL reset_stall: got %b want 0", stall_req); end
    n_checks++; if (hazard !== 1'b0) begin n_errors++; $display("FAIL reset_hazard: got %b want 0", hazard); end
    n_checks++; if (b_ready !== 1'b1) begin n_errors++; $display("FAIL reset_b_ready: got %b want 1", b_ready); end
    @(negedge clk); rst = 1'b1;
  endtask

  task automatic test_a_only();
    idle_inputs();
    a_valid = 1; a_addr = 5'd5; a_data = 32'hDEADBEEF;
    tick();
    n_checks++; if (wr_en !== 1'b1) begin n_errors++; $display("FAIL a_only_en: got %b want 1", wr_en); end
    n_checks++; if (wr_addr !== 5'd5) begin n_errors++; $display("FAIL a_only_addr: got %0d want 5", wr_addr); end
    n_checks++; if (wr_data !== 32'hDEADBEEF) begin n_errors++; $display("FAIL a_only_data: got %h want deadbeef", wr_data); end
    n_checks++; if (JumpAndLink !== 1'b0) begin n_errors++; $display("FAIL a_only_jal: got %b want 0", JumpAndLink); end
    a_valid = 0;
    tick();
    n_checks++; if (wr_en !== 1'b0) begin n_errors++; $display("FAIL a_only_idle_en: got %b want 0", wr_en); end
  endtask

  task automatic test_jal_and_reg0();
    idle_inputs();
    a_valid = 1; a_jal = 1; a_addr = 5'd0; a_data = 32'h00400008;
    tick();
    n_checks++; if (wr_en !== 1'b1) begin n_errors++; $display("FAIL jal_en: got %b want 1", wr_en); end
    n_checks++; if (wr_addr !== 5'd31) begin n_errors++; $display("FAIL jal_addr: got %0d want 31", wr_addr); end
    n_checks++; if (wr_data !== 32'h00400008) begin n_errors++; $display("FAIL jal_data: got %h want 00400008", wr_data); end
    n_checks++; if (JumpAndLink !== 1'b1) begin n_errors++; $display("FAIL jal_strobe: got %b want 1", JumpAndLink); end
    a_jal = 0; a_addr = 5'd0; a_data = 32'h1234;
    tick();
    n_checks++; if (wr_en !== 1'b0) begin n_errors++; $display("FAIL a_reg0_en: got %b want 0", wr_en); end
    n_checks++; if (JumpAndLink !== 1'b0) begin n_errors++; $display("FAIL a_reg0_jal: got %b want 0", JumpAndLink); end
    a_valid = 0;
    tick();
  endtask

  task automatic test_scoreboard();
    idle_inputs();
    iss_valid = 1; iss_addr = 5'd8;
    tick();
    iss_valid = 0; chk_addr0 = 5'd8; #1;
    n_checks++; if (hazard !== 1'b1) begin n_errors++; $display("FAIL sb_hazard_set: got %b want 1", hazard); end
    b_valid = 1; b_addr = 5'd8; b_data = 32'h12;
    tick();
    b_valid = 0;
    n_checks++; if (hazard !== 1'b1) begin n_errors++; $display("FAIL sb_hazard_queued: got %b want 1", hazard); end
    tick();
    n_checks++; if (hazard !== 1'b0) begin n_errors++; $display("FAIL sb_hazard_clr: got %b want 0", hazard); end
    n_checks++; if (wr_en !== 1'b1 || wr_addr !== 5'd8) begin n_errors++; $display("FAIL sb_write: got en=%b addr=%0d want en=1 addr=8", wr_en, wr_addr); end
    n_checks++; if (wr_data !== 32'h12) begin n_errors++; $display("FAIL sb_data: got %h want 12", wr_data); end
  endtask

  task automatic test_starvation();
    idle_inputs();
    a_valid = 1; a_addr = 5'd3; a_data = 32'h33;
    b_valid = 1; b_addr = 5'd12; b_data = 32'hABC;
    tick();
    b_valid = 0;
    n_checks++; if (stall_req !== 1'b0) begin n_errors++; $display("FAIL starve_c0: got %b want 0", stall_req); end
    for (int i = 1; i <= LIM + 1; i++) begin
      tick();
      n_checks++;
      if (stall_req !== (i >= LIM)) begin n_errors++; $display("FAIL starve_c%0d: got %b want %b", i, stall_req, (i >= LIM)); end
    end
    n_checks++; if (wr_en !== 1'b1 || wr_addr !== 5'd3) begin n_errors++; $display("FAIL starve_a_kept: got en=%b addr=%0d want en=1 addr=3", wr_en, wr_addr); end
    a_valid = 0;
    tick();
    n_checks++; if (wr_en !== 1'b1 || wr_addr !== 5'd12 || wr_data !== 32'hABC) begin n_errors++; $display("FAIL starve_b_write: got en=%b addr=%0d data=%h want 1 12 abc", wr_en, wr_addr, wr_data); end
    n_checks++; if (stall_req !== 1'b0) begin n_errors++; $display("FAIL starve_release: got %b want 0", stall_req); end
  endtask

  task automatic test_full_reg0();
    idle_inputs();
    a_valid = 1; a_addr = 5'd2; b_valid = 1;
    for (int i = 0; i < 3; i++) begin
      b_addr = 5'(4 + i); b_data = 32'(100 + i); #1;
      n_checks++;
      if (b_ready !== (i < 2)) begin n_errors++; $display("FAIL full_ready_push%0d: got %b want %b", i, b_ready, (i < 2)); end
      tick();
    end
    b_valid = 0; a_valid = 0;
    for (int i = 0; i < 3; i++) begin
      tick();
      n_checks++;
      if (wr_en !== (i < 2) || (i < 2 && wr_addr !== 5'(4 + i))) begin
        n_errors++; $display("FAIL full_drain%0d: got en=%b addr=%0d want en=%b addr=%0d", i, wr_en, wr_addr, (i < 2), 4 + i);
      end
    end
    b_valid = 1; b_addr = 5'd0; b_data = 32'h77;
    tick();
    b_valid = 0;
    tick();
    n_checks++; if (wr_en !== 1'b0) begin n_errors++; $display("FAIL b_reg0_en: got %b want 0", wr_en); end
    n_checks++; if (b_ready !== 1'b1) begin n_errors++; $display("FAIL b_reg0_popped: got %b want 1", b_ready); end
  endtask

  task automatic test_random();
    logic exp_hz;
    idle_inputs();
    for (int c = 0; c < 400; c++) begin
      a_valid   = ($urandom_range(0, 99) < ((c < 200) ? 45 : 85));
      a_jal     = ($urandom_range(0, 7) == 0);
      a_addr    = 5'($urandom);
      a_data    = $urandom;
      b_valid   = ($urandom_range(0, 1) == 1);
      b_addr    = ($urandom_range(0, 5) == 0) ? 5'd0 : 5'($urandom);
      b_data    = $urandom;
      iss_valid = ($urandom_range(0, 2) == 0);
      iss_addr  = 5'($urandom);
      chk_addr0 = 5'($urandom);
      chk_addr1 = 5'($urandom);
      tick();
      exp_hz = mpend[chk_addr0] | mpend[chk_addr1];
      n_checks++; if (wr_en !== e_en) begin n_errors++; $display("FAIL rnd%0d_en: got %b want %b", c, wr_en, e_en); end
      if (e_en) begin
        n_checks++;
        if (wr_addr !== e_addr || wr_data !== e_data) begin n_errors++; $display("FAIL rnd%0d_wr: got %0d/%h want %0d/%h", c, wr_addr, wr_data, e_addr, e_data); end
      end
      n_checks++; if (JumpAndLink !== e_jal) begin n_errors++; $display("FAIL rnd%0d_jal: got %b want %b", c, JumpAndLink, e_jal); end
      n_checks++; if (stall_req !== mstall) begin n_errors++; $display("FAIL rnd%0d_stall: got %b want %b", c, stall_req, mstall); end
      n_checks++; if (b_ready !== (mq.size() < 2)) begin n_errors++; $display("FAIL rnd%0d_ready: got %b want %b", c, b_ready, (mq.size() < 2)); end
      n_checks++; if (hazard !== exp_hz) begin n_errors++; $display("FAIL rnd%0d_hazard: got %b want %b", c, hazard, exp_hz); end
    end
    idle_inputs();
    for (int i = 0; i < 3; i++) tick();
  endtask

  task automatic test_reset_mid();
    idle_inputs();
    a_valid = 1; a_addr = 5'd1; b_valid = 1; b_addr = 5'd10; b_data = 32'hA;
    iss_valid = 1; iss_addr = 5'd9;
    tick();
    iss_valid = 0; b_addr = 5'd11; b_data = 32'hB;
    tick();
    b_valid = 0; chk_addr0 = 5'd9; #1;
    n_checks++; if (b_ready !== 1'b0 || hazard !== 1'b1) begin n_errors++; $display("FAIL mid_pre: got ready=%b hazard=%b want 0 1", b_ready, hazard); end
    @(negedge clk); rst = 1'b0; #1;
    a_valid = 0; model_reset(); #1;
    n_checks++; if (b_ready !== 1'b1) begin n_errors++; $display("FAIL mid_ready: got %b want 1", b_ready); end
    n_checks++; if (hazard !== 1'b0) begin n_errors++; $display("FAIL mid_hazard: got %b want 0", hazard); end
    n_checks++; if (wr_en !== 1'b0 || stall_req !== 1'b0) begin n_errors++; $display("FAIL mid_outputs: got en=%b stall=%b want 0 0", wr_en, stall_req); end
    @(negedge clk); rst = 1'b1;
    for (int i = 0; i < 4; i++) begin
      tick();
      n_checks++;
      if (wr_en !== 1'b0 || hazard !== 1'b0) begin n_errors++; $display("FAIL mid_after%0d: got en=%b hazard=%b want 0 0", i, wr_en, hazard); end
    end
  endtask

  initial begin
    test_reset();
    test_a_only();
    test_jal_and_reg0();
    test_scoreboard();
    test_starvation();
    test_full_reg0();
    test_random();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
